// File: rtl/bus_dma.sv
// ---------------------------------------------------------------------------
// bus_dma -- single-channel memory-to-memory DMA master on a shared bus.
//
// A start pulse in IDLE latches a source pointer, a destination pointer and a
// word count. The block requests the bus once and keeps the request high for
// the whole transfer. For each word it performs a read address phase, waits
// for the slave DONE, then a write address phase, a write data phase and a
// wait for the slave DONE. Losing the grant mid-transfer aborts the transfer
// and sets the sticky err flag.
//
// Optional feature: define BUS_DMA_TIMEOUT_EN to add an 8-bit watchdog. It
// aborts a transfer when a slave leaves RD_WAIT/WR_WAIT without DONE for
// 255 cycles. Without the macro the block waits indefinitely.
//
// Parameters
//   A_WIDTH    address width
//   D_WIDTH    bus data width
//   C_WIDTH    bus control width (bit0 RD, bit1 WR, bit2 WDAT, bit3 DONE)
//   LEN_WIDTH  transfer length width
//
// Ports
//   clk           system clock, all state changes on posedge
//   reset_L       asynchronous active-low reset
//   start         one-cycle launch pulse, honoured only in IDLE
//   src_addr      first source word address, sampled on start
//   dst_addr      first destination word address, sampled on start
//   len           word count, sampled on start (0 = immediate done)
//   bus_req       bus request to the arbiter
//   bus_ack       arbiter grant
//   bus_data_in   shared bus data (read data captured on slave DONE)
//   bus_ctrl_in   shared bus control (bit3 = slave DONE)
//   bus_data_out  master data drive, zero when not granted
//   bus_ctrl_out  master control drive, zero when not granted
//   busy          transfer in progress (REQ through DONE)
//   done          one-cycle completion/abort pulse
//   err           sticky abort flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module bus_dma #(
    parameter int A_WIDTH   = 32,
    parameter int D_WIDTH   = 32,
    parameter int C_WIDTH   = 8,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [A_WIDTH-1:0]   src_addr,
    input  logic [A_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 bus_req,
    input  logic                 bus_ack,
    input  logic [D_WIDTH-1:0]   bus_data_in,
    input  logic [C_WIDTH-1:0]   bus_ctrl_in,
    output logic [D_WIDTH-1:0]   bus_data_out,
    output logic [C_WIDTH-1:0]   bus_ctrl_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // Bus control bit positions.
    localparam int CTRL_RD   = 0;
    localparam int CTRL_WR   = 1;
    localparam int CTRL_WDAT = 2;
    localparam int CTRL_DONE = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_ADDR,
        S_RD_WAIT,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [A_WIDTH-1:0]    src_ptr;
    logic [A_WIDTH-1:0]    dst_ptr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [D_WIDTH-1:0]    hold;
    logic                  err_q;
    logic                  zero_done;

    logic                  slave_done;
    logic                  in_tenure;
    logic                  in_wait;
    logic                  grant_lost;
    logic                  timeout;
    logic                  abort;
    logic                  accept;

    // Only the DONE bit of the incoming control bus is meaningful to a master.
    logic                  ctrl_in_unused;
    assign ctrl_in_unused = ^bus_ctrl_in;

    assign slave_done = bus_ctrl_in[CTRL_DONE];
    assign accept     = (state == S_IDLE) && start;

    // States in which the block owns the bus and must keep the grant.
    assign in_tenure = (state == S_RD_ADDR) || (state == S_RD_WAIT) ||
                       (state == S_WR_ADDR) || (state == S_WR_DATA) ||
                       (state == S_WR_WAIT);
    assign in_wait   = (state == S_RD_WAIT) || (state == S_WR_WAIT);

    assign grant_lost = in_tenure && !bus_ack;

`ifdef BUS_DMA_TIMEOUT_EN
    // Watchdog: zero on the first cycle of a wait state, so the 255th
    // consecutive wait cycle sees 254. A DONE arriving on that same cycle
    // still wins.
    logic [7:0] wd_cnt;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wd_cnt <= '0;
        end else if (!in_wait) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign timeout = in_wait && (wd_cnt == 8'd254) && !slave_done;
`else
    assign timeout = 1'b0;
`endif

    assign abort = grant_lost || timeout;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    next_state = S_RD_ADDR;
                end
            end
            S_RD_ADDR: next_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (slave_done) begin
                    next_state = S_WR_ADDR;
                end
            end
            S_WR_ADDR: next_state = S_WR_DATA;
            S_WR_DATA: next_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (slave_done) begin
                    next_state = (remaining == LEN_WIDTH'(1)) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase

        // Grant loss and watchdog expiry override any slave response.
        if (abort) begin
            next_state = S_DONE;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: pointers, word counter, holding register, flags
    // -----------------------------------------------------------------------
    // NOTE: the holding register is reset with the rest of the datapath so a
    // reset mid-transfer never leaves a stale word behind.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            hold      <= '0;
            err_q     <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            // A zero-length start produces its done pulse on the next cycle
            // without leaving IDLE.
            zero_done <= accept && (len == '0);

            if (accept) begin
                err_q <= 1'b0;
                if (len != '0) begin
                    src_ptr   <= src_addr;
                    dst_ptr   <= dst_addr;
                    remaining <= len;
                end
            end

            if (abort) begin
                err_q <= 1'b1;
            end else if (slave_done) begin
                if (state == S_RD_WAIT) begin
                    hold <= bus_data_in;
                end
                if (state == S_WR_WAIT) begin
                    // Pointers wrap silently at 2^A_WIDTH.
                    src_ptr   <= src_ptr + A_WIDTH'(1);
                    dst_ptr   <= dst_ptr + A_WIDTH'(1);
                    remaining <= remaining - LEN_WIDTH'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from state; bus drive gated by the grant)
    // -----------------------------------------------------------------------
    assign bus_req = (state == S_REQ) || in_tenure;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE) || zero_done;
    assign err     = err_q;

    always_comb begin
        bus_data_out = '0;
        bus_ctrl_out = '0;
        if (bus_ack) begin
            case (state)
                S_RD_ADDR: begin
                    bus_data_out          = D_WIDTH'(src_ptr);
                    bus_ctrl_out[CTRL_RD] = 1'b1;
                end
                S_WR_ADDR: begin
                    bus_data_out          = D_WIDTH'(dst_ptr);
                    bus_ctrl_out[CTRL_WR] = 1'b1;
                end
                S_WR_DATA: begin
                    bus_data_out            = hold;
                    bus_ctrl_out[CTRL_WDAT] = 1'b1;
                end
                default: begin
                    bus_data_out = '0;
                    bus_ctrl_out = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// ---------------------------------------------------------------------------
// tb_bus_dma -- self-checking bench for bus_dma.
//
// A behavioural slave answers each read address phase and each write data
// phase with DONE one cycle later, returning data from a fixed address hash.
// Expected writes (address, data) are queued when a transfer is launched and
// popped as the slave observes write data phases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bus_dma;

    localparam int  A_W = 32;
    localparam int  D_W = 32;
    localparam int  C_W = 8;
    localparam int  L_W = 16;
    localparam time T_HALF = 20ns;

    localparam logic [C_W-1:0] C_RD   = 8'h01;
    localparam logic [C_W-1:0] C_WR   = 8'h02;
    localparam logic [C_W-1:0] C_WDAT = 8'h04;

    typedef struct packed {
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
    } wr_t;

    logic           clk;
    logic           reset_L;
    logic           start;
    logic [A_W-1:0] src_addr;
    logic [A_W-1:0] dst_addr;
    logic [L_W-1:0] len;
    logic           bus_req;
    logic           bus_ack;
    logic [D_W-1:0] bus_data_in;
    logic [C_W-1:0] bus_ctrl_in;
    logic [D_W-1:0] bus_data_out;
    logic [C_W-1:0] bus_ctrl_out;
    logic           busy;
    logic           done;
    logic           err;

    int n_checks;
    int n_errors;

    wr_t            exp_q[$];
    logic [A_W-1:0] rd_addrs[$];
    int             rd_count;
    int             write_count;
    int             abort_rd;
    bit             slave_mute;
    bit             pend_rd;
    bit             pend_wr;
    logic [A_W-1:0] rd_addr;
    logic [A_W-1:0] wr_addr;
    int             done_cnt;
    int             req_gap;

    bus_dma #(
        .A_WIDTH   (A_W),
        .D_WIDTH   (D_W),
        .C_WIDTH   (C_W),
        .LEN_WIDTH (L_W)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .bus_req      (bus_req),
        .bus_ack      (bus_ack),
        .bus_data_in  (bus_data_in),
        .bus_ctrl_in  (bus_ctrl_in),
        .bus_data_out (bus_data_out),
        .bus_ctrl_out (bus_ctrl_out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #(T_HALF) clk = ~clk;

    function automatic logic [D_W-1:0] mem_word(input logic [A_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input logic [A_W-1:0] s, input logic [A_W-1:0] d, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = d + A_W'(i);
            e.data = mem_word(s + A_W'(i));
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [A_W-1:0] s, input logic [A_W-1:0] d, input logic [L_W-1:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Behavioural slave and scoreboard consumer.
    always @(negedge clk) begin
        wr_t e;
        if (!reset_L) begin
            pend_rd     = 1'b0;
            pend_wr     = 1'b0;
            bus_ctrl_in = '0;
            bus_data_in = '0;
        end else begin
            bus_ctrl_in = '0;
            bus_data_in = '0;
            if (pend_rd) begin
                bus_ctrl_in[3] = 1'b1;
                bus_data_in    = mem_word(rd_addr);
                pend_rd        = 1'b0;
                if (abort_rd != 0 && rd_count == abort_rd) begin
                    bus_ack = 1'b0;
                end
            end
            if (pend_wr) begin
                bus_ctrl_in[3] = 1'b1;
                pend_wr        = 1'b0;
            end
            case (bus_ctrl_out)
                C_RD: begin
                    rd_addr = bus_data_out;
                    rd_addrs.push_back(bus_data_out);
                    rd_count++;
                    pend_rd = !slave_mute;
                end
                C_WR: wr_addr = bus_data_out;
                C_WDAT: begin
                    write_count++;
                    pend_wr = !slave_mute;
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(e.addr));
                        check("wr_data", 64'(bus_data_out), 64'(e.data));
                    end
                end
                default: ;
            endcase
        end
    end

    // Protocol monitor: done pulses and bus request continuity.
    always @(negedge clk) begin
        if (reset_L) begin
            if (done) done_cnt++;
            if (busy && !done && !bus_req) req_gap++;
        end
    end

    initial begin
        #(2_000_000ns);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        int base;
        int low_cnt;
        bit found;

        n_checks    = 0;
        n_errors    = 0;
        rd_count    = 0;
        write_count = 0;
        abort_rd    = 0;
        slave_mute  = 1'b0;
        done_cnt    = 0;
        req_gap     = 0;
        reset_L     = 1'b0;
        start       = 1'b0;
        src_addr    = '0;
        dst_addr    = '0;
        len         = '0;
        bus_ack     = 1'b1;
        bus_data_in = '0;
        bus_ctrl_in = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_bus_req",  64'(bus_req),      64'd0);
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_done",     64'(done),         64'd0);
        check("rst_err",      64'(err),          64'd0);
        check("rst_data_out", 64'(bus_data_out), 64'd0);
        check("rst_ctrl_out", 64'(bus_ctrl_out), 64'd0);

        // Three-word copy; start asserted together with reset release.
        push_expected(32'h100, 32'h2000, 3);
        @(negedge clk);
        reset_L  = 1'b1;
        src_addr = 32'h100;
        dst_addr = 32'h2000;
        len      = 16'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_start_busy", 64'(busy), 64'd1);
        wait_done("copy3", 200, cyc);
        check("copy3_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        check("copy3_done_pulses", 64'(done_cnt),     64'd1);
        check("copy3_req_gap",     64'(req_gap),      64'd0);
        check("copy3_writes",      64'(write_count),  64'd3);
        check("copy3_queue_empty", 64'(exp_q.size()), 64'd0);
        check("copy3_busy_after",  64'(busy),         64'd0);

        // Zero-length start.
        done_cnt = 0;
        @(negedge clk);
        len   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_done",    64'(done),    64'd1);
        check("len0_busy",    64'(busy),    64'd0);
        check("len0_bus_req", 64'(bus_req), 64'd0);
        @(negedge clk);
        check("len0_done_clr", 64'(done),    64'd0);
        check("len0_bus_req2", 64'(bus_req), 64'd0);
        check("len0_busy2",    64'(busy),    64'd0);

        // Grant lost in RD_WAIT of word 2 of a four-word copy.
        write_count = 0;
        abort_rd    = rd_count + 2;
        push_expected(32'h300, 32'h4000, 1);
        do_start(32'h300, 32'h4000, 16'd4);
        wait_done("abort", 200, cyc);
        check("abort_err",     64'(err),     64'd1);
        check("abort_bus_req", 64'(bus_req), 64'd0);
        @(posedge clk);
        #1;
        check("abort_req_after",  64'(bus_req), 64'd0);
        check("abort_busy_after", 64'(busy),    64'd0);
        check("abort_done_clr",   64'(done),    64'd0);
        check("abort_err_sticky", 64'(err),     64'd1);
        abort_rd = 0;
        bus_ack  = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_writes",      64'(write_count),  64'd1);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

        // Source pointer wrap; also err must clear on the accepted start.
        base = rd_addrs.size();
        push_expected(32'hFFFF_FFFF, 32'h10, 2);
        do_start(32'hFFFF_FFFF, 32'h10, 16'd2);
        check("wrap_err_cleared", 64'(err), 64'd0);
        wait_done("wrap", 200, cyc);
        repeat (2) @(negedge clk);
        check("wrap_rd_count", 64'(rd_addrs.size() - base), 64'd2);
        if (rd_addrs.size() >= base + 2) begin
            check("wrap_second_rd_addr", 64'(rd_addrs[base+1]), 64'd0);
        end
        check("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted during WR_DATA.
        do_start(32'h500, 32'h6000, 16'd2);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus_ctrl_out == C_WDAT) begin
                found = 1'b1;
                break;
            end
        end
        check("wr_data_reached", 64'(found), 64'd1);
        #2;
        reset_L = 1'b0;
        #1;
        check("midrst_bus_req",  64'(bus_req),      64'd0);
        check("midrst_busy",     64'(busy),         64'd0);
        check("midrst_done",     64'(done),         64'd0);
        check("midrst_err",      64'(err),          64'd0);
        check("midrst_data_out", 64'(bus_data_out), 64'd0);
        check("midrst_ctrl_out", 64'(bus_ctrl_out), 64'd0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        push_expected(32'h700, 32'h8000, 1);
        do_start(32'h700, 32'h8000, 16'd1);
        wait_done("post_rst", 100, cyc);
        check("post_rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        check("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Slave never answers.
        slave_mute = 1'b1;
        done_cnt   = 0;
        do_start(32'h900, 32'hA000, 16'd1);
`ifdef BUS_DMA_TIMEOUT_EN
        // REQ, RD_ADDR, 255 RD_WAIT cycles, then DONE.
        wait_done("watchdog", 400, cyc);
        check("watchdog_err",    64'(err), 64'd1);
        check("watchdog_cycles", 64'(cyc), 64'd257);
`else
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) low_cnt++;
        end
        check("hang_busy_low_cycles", 64'(low_cnt),  64'd0);
        check("hang_done_pulses",     64'(done_cnt), 64'd0);
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
`endif
        slave_mute = 1'b0;
        repeat (2) @(negedge clk);
        check("final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
